// File: rtl/matrix_transpose_stream_if.sv
// Stream bundle for matrix_transpose_stream: opcode, row input/output handshakes and status.
// The engine connects through the slave modport; the producer/consumer side uses master.
interface matrix_transpose_stream_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIM    = 4
);
  logic [2:0]            Operation;
  logic                  InValid;
  logic                  InReady;
  logic [DIM*DATA_W-1:0] InRow;
  logic                  OutValid;
  logic                  OutReady;
  logic [DIM*DATA_W-1:0] OutRow;
  logic                  Done;
  logic                  Error;

  modport master (
    output Operation, InValid, InRow, OutReady,
    input  InReady, OutValid, OutRow, Done, Error
  );

  modport slave (
    input  Operation, InValid, InRow, OutReady,
    output InReady, OutValid, OutRow, Done, Error
  );
endinterface

// File: rtl/matrix_transpose_stream.sv
// DIM x DIM transpose engine: loads a matrix row-by-row, then streams out its columns as rows.
// Define TRANSPOSE_NEGATE_EN to add opcode 3'b101 (saturating negated transpose).
module matrix_transpose_stream #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DIM    = 4
) (
  input  logic                     Clock,
  input  logic                     ClearAll,
  matrix_transpose_stream_if.slave bus_io
);

  localparam int unsigned   CntW    = $clog2(DIM);
  localparam logic [CntW-1:0] LastIdx = CntW'(DIM - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StLoad  = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [2:0] OpIdle  = 3'b000;
  localparam logic [2:0] OpTrans = 3'b100;

  logic [1:0]        state_q, state_d;
  logic [CntW-1:0]   row_q, row_d;
  logic [CntW-1:0]   col_q, col_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [DATA_W-1:0] mem_q [DIM][DIM];
  logic [DATA_W-1:0] mem_d [DIM][DIM];
  logic              op_supported;
  logic              in_fire;
  logic              out_fire;
  logic [DIM*DATA_W-1:0] out_row;

`ifdef TRANSPOSE_NEGATE_EN
  localparam logic [2:0] OpNeg = 3'b101;

  logic neg_q, neg_d;

  // Two's complement min has no positive counterpart; clamp to max.
  function automatic logic [DATA_W-1:0] sat_neg(input logic [DATA_W-1:0] v);
    if (v == {1'b1, {(DATA_W-1){1'b0}}}) begin
      return {1'b0, {(DATA_W-1){1'b1}}};
    end
    return -v;
  endfunction

  assign op_supported = (bus_io.Operation == OpTrans) || (bus_io.Operation == OpNeg);
`else
  assign op_supported = (bus_io.Operation == OpTrans);
`endif

  assign in_fire  = bus_io.InValid && (state_q == StLoad);
  assign out_fire = bus_io.OutReady && (state_q == StDrain);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    error_d = 1'b0;
    mem_d   = mem_q;
`ifdef TRANSPOSE_NEGATE_EN
    neg_d   = neg_q;
`endif
    case (state_q)
      StIdle: begin
        if (op_supported) begin
          state_d = StLoad;
          row_d   = '0;
          col_d   = '0;
`ifdef TRANSPOSE_NEGATE_EN
          neg_d   = (bus_io.Operation == OpNeg);
`endif
        end else if (bus_io.Operation != OpIdle) begin
          error_d = 1'b1;
        end
      end
      StLoad: begin
        if (in_fire) begin
          for (int unsigned c = 0; c < DIM; c++) begin
            mem_d[row_q][c] = bus_io.InRow[c*DATA_W +: DATA_W];
          end
          if (row_q == LastIdx) begin
            state_d = StDrain;
            row_d   = '0;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (out_fire) begin
          if (col_q == LastIdx) begin
            state_d = StIdle;
            col_d   = '0;
            done_d  = 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output row k gathers column k of the buffer; forced to zero outside DRAIN.
  always_comb begin
    out_row = '0;
    if (state_q == StDrain) begin
      for (int unsigned j = 0; j < DIM; j++) begin
`ifdef TRANSPOSE_NEGATE_EN
        out_row[j*DATA_W +: DATA_W] = neg_q ? sat_neg(mem_q[j][col_q]) : mem_q[j][col_q];
`else
        out_row[j*DATA_W +: DATA_W] = mem_q[j][col_q];
`endif
      end
    end
  end

  always_ff @(posedge Clock or negedge ClearAll) begin
    if (!ClearAll) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      for (int unsigned i = 0; i < DIM; i++) begin
        for (int unsigned j = 0; j < DIM; j++) begin
          mem_q[i][j] <= '0;
        end
      end
`ifdef TRANSPOSE_NEGATE_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      done_q  <= done_d;
      error_q <= error_d;
      mem_q   <= mem_d;
`ifdef TRANSPOSE_NEGATE_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign bus_io.InReady  = (state_q == StLoad);
  assign bus_io.OutValid = (state_q == StDrain);
  assign bus_io.OutRow   = out_row;
  assign bus_io.Done     = done_q;
  assign bus_io.Error    = error_q;

endmodule

// File: tb/tb_matrix_transpose_stream.sv
// Scoreboard bench for matrix_transpose_stream: directed matrices, backpressure, gaps,
// bad opcodes and mid-load reset; honours TRANSPOSE_NEGATE_EN for the 3'b101 case.
module tb_matrix_transpose_stream;
  localparam int DW  = 32;
  localparam int DIM = 4;
  localparam int RW  = DW * DIM;

  logic Clock    = 1'b0;
  logic ClearAll = 1'b0;
  always #5 Clock = ~Clock;

  matrix_transpose_stream_if #(.DATA_W(DW), .DIM(DIM)) bus ();

  matrix_transpose_stream #(.DATA_W(DW), .DIM(DIM)) dut (
    .Clock    (Clock),
    .ClearAll (ClearAll),
    .bus_io   (bus)
  );

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  logic [RW-1:0] sb [$];
  logic [RW-1:0] in_rows [4];

  function automatic logic [RW-1:0] pk(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_basic();
    in_rows[0] = pk(1, 2, 3, 4);
    in_rows[1] = pk(5, 6, 7, 8);
    in_rows[2] = pk(9, 10, 11, 12);
    in_rows[3] = pk(13, 14, 15, 16);
  endtask

  task automatic push_basic();
    sb.push_back(pk(1, 5, 9, 13));
    sb.push_back(pk(2, 6, 10, 14));
    sb.push_back(pk(3, 7, 11, 15));
    sb.push_back(pk(4, 8, 12, 16));
  endtask

  task automatic run_load(input logic [2:0] op, input int nrows, input bit gaps);
    int t;
    @(posedge Clock); #1;
    bus.Operation = op;
    t = 0;
    while (!bus.InReady && t < 20) begin
      @(posedge Clock); #1;
      t++;
    end
    chk("load_entry", RW'(bus.InReady), RW'(1));
    bus.Operation = 3'b000;
    for (int r = 0; r < nrows; r++) begin
      bus.InValid = 1'b1;
      bus.InRow   = in_rows[r];
      @(posedge Clock); #1;
      if (gaps) begin
        bus.InValid = 1'b0;
        bus.InRow   = '0;
        @(posedge Clock); #1;
      end
    end
    bus.InValid = 1'b0;
    bus.InRow   = '0;
  endtask

  task automatic wait_drain(input int exp_done);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge Clock); #1;
      t++;
    end
    chk("drain_empty", RW'(sb.size()), RW'(0));
    @(posedge Clock); #1;
    chk("done_count", RW'(done_cnt), RW'(exp_done));
    chk("idle_inready", RW'(bus.InReady), RW'(0));
    chk("idle_outvalid", RW'(bus.OutValid), RW'(0));
  endtask

  task automatic chk_reset_outputs();
    chk("rst_inready", RW'(bus.InReady), RW'(0));
    chk("rst_outvalid", RW'(bus.OutValid), RW'(0));
    chk("rst_outrow", bus.OutRow, RW'(0));
    chk("rst_done", RW'(bus.Done), RW'(0));
    chk("rst_error", RW'(bus.Error), RW'(0));
  endtask

  // Monitor: compare every presented output row, pop on transfer.
  always @(negedge Clock) begin
    if (ClearAll) begin
      if (bus.OutValid) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", bus.OutRow, RW'(0));
        end else begin
          chk("out_row", bus.OutRow, sb[0]);
          if (bus.OutReady) void'(sb.pop_front());
        end
      end else begin
        chk("out_zero", bus.OutRow, RW'(0));
      end
      if (bus.Done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Operation = 3'b000;
    bus.InValid   = 1'b0;
    bus.InRow     = '0;
    bus.OutReady  = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk_reset_outputs();
    @(posedge Clock); #1;
    ClearAll = 1'b1;

    // Basic 4x4
    set_basic();
    push_basic();
    run_load(3'b100, 4, 1'b0);
    wait_drain(1);

    // Backpressure on output row 2
    push_basic();
    bus.OutReady = 1'b0;
    run_load(3'b100, 4, 1'b0);
    begin
      int t;
      t = 0;
      while (!bus.OutValid && t < 20) begin
        @(posedge Clock); #1;
        t++;
      end
    end
    chk("bp_first", bus.OutRow, pk(1, 5, 9, 13));
    bus.OutReady = 1'b1;
    @(posedge Clock); #1;
    bus.OutReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      chk("bp_hold", bus.OutRow, pk(2, 6, 10, 14));
      @(posedge Clock);
    end
    #1;
    bus.OutReady = 1'b1;
    wait_drain(2);

    // InValid gaps between rows
    push_basic();
    run_load(3'b100, 4, 1'b1);
    wait_drain(3);

    // Unsupported opcode held for 5 cycles
    @(posedge Clock); #1;
    bus.Operation = 3'b011;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      chk("bad_error", RW'(bus.Error), RW'(i == 0 ? 0 : 1));
      chk("bad_inready", RW'(bus.InReady), RW'(0));
    end
    @(posedge Clock); #1;
    bus.Operation = 3'b000;
    @(negedge Clock);
    chk("bad_error_hold", RW'(bus.Error), RW'(1));
    @(negedge Clock);
    chk("bad_error_clear", RW'(bus.Error), RW'(0));

    // Reset after two rows, then a fresh load
    run_load(3'b100, 2, 1'b0);
    ClearAll = 1'b0;
    @(negedge Clock);
    chk_reset_outputs();
    @(posedge Clock); #1;
    ClearAll = 1'b1;
    push_basic();
    run_load(3'b100, 4, 1'b0);
    wait_drain(4);

`ifdef TRANSPOSE_NEGATE_EN
    in_rows[0] = pk(32'h8000_0000, 5, 0, 0);
    in_rows[1] = pk(0, 0, 0, 0);
    in_rows[2] = pk(0, 0, 0, 32'hFFFF_FFF9);
    in_rows[3] = pk(1, 0, 0, 0);
    sb.push_back(pk(32'h7FFF_FFFF, 0, 0, 32'hFFFF_FFFF));
    sb.push_back(pk(32'hFFFF_FFFB, 0, 0, 0));
    sb.push_back(pk(0, 0, 0, 0));
    sb.push_back(pk(0, 0, 7, 0));
    run_load(3'b101, 4, 1'b0);
    wait_drain(5);
`else
    @(posedge Clock); #1;
    bus.Operation = 3'b101;
    @(posedge Clock);
    @(negedge Clock);
    chk("neg_off_error", RW'(bus.Error), RW'(1));
    chk("neg_off_inready", RW'(bus.InReady), RW'(0));
    @(posedge Clock); #1;
    bus.Operation = 3'b000;
    @(posedge Clock);
    @(negedge Clock);
    chk("neg_off_clear", RW'(bus.Error), RW'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
